// File: rtl/pulse2width.sv
// rtl/pulse2width.sv - measures the high width of a level on pulse_in in sys_clk cycles
module pulse2width #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int CONTINUOUS  = 0
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             enable,
    input  logic             arm,
    input  logic             pulse_in,
    output logic [WIDTH-1:0] width_out,
    output logic [WIDTH-1:0] start_out,
    output logic [WIDTH-1:0] stop_out,
    output logic             width_valid,
    output logic             overflow,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_LOW = 2'd1,
        ARMED    = 2'd2,
        MEASURE  = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    state_t                 state;
    state_t                 state_next;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   s_d;
    logic                   rise;
    logic                   fall;
    logic [WIDTH-1:0]       tb;
    logic [WIDTH-1:0]       cnt;
    logic [WIDTH-1:0]       start_reg;
    logic                   ovf_reg;
    logic                   capture_start;
    logic                   finish;

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pulse_in};
            s_d    <= s;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tb <= '0;
        end else if (!enable) begin
            tb <= '0;
        end else begin
            tb <= tb + ONE;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Continuous mode returns through WAIT_LOW, so s must be seen low for two
    // cycles between pulses for the next rise to be caught.
    always_comb begin
        state_next    = state;
        capture_start = 1'b0;
        finish        = 1'b0;
        case (state)
            IDLE: begin
                if (arm) begin
                    state_next = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (!s) begin
                    state_next = ARMED;
                end
            end
            ARMED: begin
                if (rise) begin
                    capture_start = 1'b1;
                    state_next    = MEASURE;
                end
            end
            MEASURE: begin
                if (fall) begin
                    finish     = 1'b1;
                    state_next = (CONTINUOUS != 0) ? WAIT_LOW : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (!enable) begin
            state_next    = IDLE;
            capture_start = 1'b0;
            finish        = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt         <= '0;
            start_reg   <= '0;
            ovf_reg     <= 1'b0;
            width_out   <= '0;
            start_out   <= '0;
            stop_out    <= '0;
            overflow    <= 1'b0;
            width_valid <= 1'b0;
            busy        <= 1'b0;
        end else begin
            width_valid <= 1'b0;
            busy        <= (state != IDLE);
            if (!enable) begin
                cnt       <= '0;
                start_reg <= '0;
                ovf_reg   <= 1'b0;
            end else begin
                if (capture_start) begin
                    start_reg <= tb;
                    cnt       <= ONE;
                    ovf_reg   <= 1'b0;
                end else if (state == MEASURE && s) begin
                    // Saturate the count; remember that the pulse outlived it.
                    if (cnt == ALL_ONES) begin
                        ovf_reg <= 1'b1;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                if (finish) begin
                    width_out   <= cnt;
                    start_out   <= start_reg;
                    stop_out    <= tb;
                    overflow    <= ovf_reg;
                    width_valid <= 1'b1;
                end
            end
        end
    end

endmodule
